// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and a state-class helper.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // States in which a frame is in flight: bytes accepted, CPU stalled, timeout armed.
    function automatic logic is_loading(input state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Collects payload bytes little-endian; presents the full word combinationally with the 4th byte.
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        octet_valid,
    input  logic [7:0]  octet,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] low;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= 2'd0;
            low <= 24'd0;
        end else if (clear) begin
            idx <= 2'd0;
            low <= 24'd0;
        end else if (octet_valid) begin
            idx <= idx + 2'd1;
            case (idx)
                2'd0:    low[7:0]   <= octet;
                2'd1:    low[15:8]  <= octet;
                2'd2:    low[23:16] <= octet;
                default: ;
            endcase
        end
    end

    assign word_valid = octet_valid && (idx == 2'd3);
    assign word       = {octet, low};

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses LEN/payload/CHK frames and writes words to instruction RAM.
// Handshake: rx_valid is a 1-cycle strobe with no back-pressure; mem_we is a 1-cycle write pulse.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count,
    output logic [2:0]        dbg_state
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state, state_next;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       len_full;
    logic [7:0]        chk;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              start_ok, byte_ok, data_ok, timeout_hit, last_word;
    logic              word_valid;
    logic [31:0]       word;

    assign start_ok    = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign byte_ok     = rx_valid && is_loading(state);
    assign data_ok     = byte_ok && (state == S_DATA);
    assign timeout_hit = is_loading(state) && !byte_ok && (tmo_cnt == TMO_W'(TIMEOUT));
    assign last_word   = word_valid && ((word_count + 16'd1) == len);
    assign len_full    = {rx_byte, len_lo};

    prog_loader_byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_ok),
        .octet_valid (data_ok),
        .octet       (rx_byte),
        .word_valid  (word_valid),
        .word        (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start_ok) begin
            state_next = S_LEN_LO;
        end else if (timeout_hit) begin
            state_next = S_ERROR;
        end else if (byte_ok) begin
            case (state)
                S_LEN_LO: state_next = S_LEN_HI;
                S_LEN_HI: begin
                    if (len_full == 16'd0)                           state_next = S_CHK;
                    else if (32'(len_full) > (32'd1 << ADDR_W))      state_next = S_ERROR;
                    else                                             state_next = S_DATA;
                end
                S_DATA:   if (last_word) state_next = S_CHK;
                S_CHK:    state_next = (rx_byte == chk) ? S_DONE : S_ERROR;
                default:  ;
            endcase
        end
    end

    // Datapath: the write is registered off the 4th byte, so it lands the cycle after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            word_count <= 16'd0;
            len_lo     <= 8'd0;
            len        <= 16'd0;
            chk        <= 8'd0;
            tmo_cnt    <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                word_count <= 16'd0;
                len        <= 16'd0;
                chk        <= 8'd0;
                tmo_cnt    <= '0;
            end else begin
                if (byte_ok || !is_loading(state)) tmo_cnt <= '0;
                else                               tmo_cnt <= tmo_cnt + TMO_W'(1);
                if (byte_ok && state == S_LEN_LO) len_lo <= rx_byte;
                if (byte_ok && state == S_LEN_HI) len    <= len_full;
                if (data_ok) chk <= chk ^ rx_byte;
                if (word_valid) begin
                    mem_we     <= 1'b1;
                    mem_addr   <= ADDR_W'(word_count);
                    mem_wdata  <= word;
                    word_count <= word_count + 16'd1;
                end
            end
        end
    end

    assign cpu_stall = is_loading(state);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERROR);
    assign dbg_state = state;

endmodule
